// File: rtl/quick_spi_slave_pkg.sv
// Shared definitions for the quick_spi family: FSM encoding, ordering
// constants and the frame-bit to word-bit mapping used by master and slave.
package quick_spi_defs;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int unsigned LITTLE_ENDIAN = 0;
    localparam int unsigned BIG_ENDIAN    = 1;
    localparam int unsigned LSB_FIRST     = 0;
    localparam int unsigned MSB_FIRST     = 1;

    // Position in a width-bit word of the k-th bit on the wire.
    function automatic int unsigned map_bit(input int unsigned k,
                                            input int unsigned width,
                                            input int unsigned bytes_order,
                                            input int unsigned bits_order);
        int unsigned b;
        int unsigned i;
        int unsigned byte_sel;
        b = k / 8;
        i = k % 8;
        byte_sel = (bytes_order == LITTLE_ENDIAN) ? b : (width / 8 - 1 - b);
        return 8 * byte_sel + ((bits_order == LSB_FIRST) ? i : (7 - i));
    endfunction

endpackage

// File: rtl/quick_spi_slave_if.sv
// Bus bundle between an SPI master side (pins + host data) and quick_spi_slave.
interface quick_spi_slave_if #(
    parameter int unsigned RX_DATA_WIDTH = 16,
    parameter int unsigned TX_DATA_WIDTH = 8
);
    logic                     enable;
    logic                     sclk;
    logic                     ss_n;
    logic                     mosi;
    logic                     miso;
    logic                     miso_oe;
    logic [TX_DATA_WIDTH-1:0] outgoing_data;
    logic [RX_DATA_WIDTH-1:0] incoming_data;
    logic                     incoming_valid;
    logic                     start_of_transaction;
    logic                     end_of_transaction;
    logic                     frame_error;
    logic                     busy;

    modport slave (
        input  enable, sclk, ss_n, mosi, outgoing_data,
        output miso, miso_oe, incoming_data, incoming_valid,
               start_of_transaction, end_of_transaction, frame_error, busy
    );

    modport master (
        output enable, sclk, ss_n, mosi, outgoing_data,
        input  miso, miso_oe, incoming_data, incoming_valid,
               start_of_transaction, end_of_transaction, frame_error, busy
    );

endinterface

// File: rtl/quick_spi_slave_sync.sv
// Two-flop synchronizer with edge pulses derived from the synchronized level.
module quick_spi_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din_i,
    output logic dout_o,
    output logic rise_o,
    output logic fall_o
);

    logic [2:0] sh_q;

    // Stages 0/1 synchronize, stage 2 holds the previous synchronized level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q <= {3{RESET_VAL}};
        end else begin
            sh_q <= {sh_q[1:0], din_i};
        end
    end

    assign dout_o = sh_q[1];
    assign rise_o = sh_q[1] & ~sh_q[2];
    assign fall_o = ~sh_q[1] & sh_q[2];

endmodule

// File: rtl/quick_spi_slave.sv
// SPI responder: oversampled sclk/ss_n/mosi, receives an RX word and sends a
// TX word per ss_n-low frame, with configurable bit/byte order and SPI mode.
module quick_spi_slave
    import quick_spi_defs::*;
#(
    parameter int unsigned RX_DATA_WIDTH = 16,
    parameter int unsigned TX_DATA_WIDTH = 8,
    parameter int unsigned BYTES_ORDER   = 0,
    parameter int unsigned BITS_ORDER    = 1,
    parameter int unsigned CPOL          = 0,
    parameter int unsigned CPHA          = 0
) (
    input logic              clk,
    input logic              reset,
    quick_spi_slave_if.slave bus
);

    localparam int unsigned RXC_W = $clog2(RX_DATA_WIDTH + 1);
    localparam int unsigned TXC_W = $clog2(TX_DATA_WIDTH + 1);
    localparam int unsigned RXI_W = $clog2(RX_DATA_WIDTH);
    localparam int unsigned TXI_W = $clog2(TX_DATA_WIDTH);

    localparam logic [RXC_W-1:0] RX_FULL = RXC_W'(RX_DATA_WIDTH);
    localparam logic [RXC_W-1:0] RX_LAST = RXC_W'(RX_DATA_WIDTH - 1);
    localparam logic [TXC_W-1:0] TX_FULL = TXC_W'(TX_DATA_WIDTH);
    localparam logic [TXI_W-1:0] TX_IDX0 =
        TXI_W'(map_bit(0, TX_DATA_WIDTH, BYTES_ORDER, BITS_ORDER));

    logic sclk_rise, sclk_fall, ss_rise, ss_fall, mosi_s;
    logic sclk_level_unused, ss_level_unused, mosi_rise_unused, mosi_fall_unused;

    quick_spi_sync #(.RESET_VAL(CPOL != 0)) u_sclk_sync (
        .clk    (clk),
        .rst    (reset),
        .din_i  (bus.sclk),
        .dout_o (sclk_level_unused),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    // Resetting the ss_n level low means a fall can only follow an observed
    // high, so a frame already in progress at reset release is never accepted.
    quick_spi_sync #(.RESET_VAL(1'b0)) u_ss_sync (
        .clk    (clk),
        .rst    (reset),
        .din_i  (bus.ss_n),
        .dout_o (ss_level_unused),
        .rise_o (ss_rise),
        .fall_o (ss_fall)
    );

    quick_spi_sync #(.RESET_VAL(1'b0)) u_mosi_sync (
        .clk    (clk),
        .rst    (reset),
        .din_i  (bus.mosi),
        .dout_o (mosi_s),
        .rise_o (mosi_rise_unused),
        .fall_o (mosi_fall_unused)
    );

    logic lead_edge, trail_edge, sample_edge, shift_edge;

    assign lead_edge   = (CPOL == 0) ? sclk_rise : sclk_fall;
    assign trail_edge  = (CPOL == 0) ? sclk_fall : sclk_rise;
    assign sample_edge = (CPHA == 0) ? lead_edge : trail_edge;
    assign shift_edge  = (CPHA == 0) ? trail_edge : lead_edge;

    state_t                   state_q;
    logic [RX_DATA_WIDTH-1:0] rx_sh_q;
    logic [TX_DATA_WIDTH-1:0] tx_sh_q;
    logic [RXC_W-1:0]         rx_cnt_q;
    logic [TXC_W-1:0]         tx_cnt_q;
    logic                     rx_full_q;
    logic                     miso_q;
    logic                     miso_oe_q;
    logic                     busy_q;
    logic                     sot_q;
    logic                     eot_q;
    logic                     ferr_q;
    logic                     iv_q;
    logic [RX_DATA_WIDTH-1:0] incoming_data_q;

    logic [RXI_W-1:0] rx_idx_d;
    logic [TXI_W-1:0] tx_idx_d;

    // Word positions of the next RX bit to store and the next TX bit to drive.
    always_comb begin
        rx_idx_d = RXI_W'(map_bit(32'(rx_cnt_q), RX_DATA_WIDTH, BYTES_ORDER, BITS_ORDER));
        tx_idx_d = TXI_W'(map_bit(32'(tx_cnt_q), TX_DATA_WIDTH, BYTES_ORDER, BITS_ORDER));
    end

    // Frame FSM with registered outputs; tx_cnt counts bits already driven.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            rx_sh_q         <= '0;
            tx_sh_q         <= '0;
            rx_cnt_q        <= '0;
            tx_cnt_q        <= '0;
            rx_full_q       <= 1'b0;
            miso_q          <= 1'b0;
            miso_oe_q       <= 1'b0;
            busy_q          <= 1'b0;
            sot_q           <= 1'b0;
            eot_q           <= 1'b0;
            ferr_q          <= 1'b0;
            iv_q            <= 1'b0;
            incoming_data_q <= '0;
        end else begin
            sot_q     <= 1'b0;
            eot_q     <= 1'b0;
            ferr_q    <= 1'b0;
            iv_q      <= 1'b0;
            rx_full_q <= 1'b0;

            if (rx_full_q) begin
                incoming_data_q <= rx_sh_q;
                iv_q            <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (ss_fall && bus.enable) begin
                        tx_sh_q   <= bus.outgoing_data;
                        rx_sh_q   <= '0;
                        rx_cnt_q  <= '0;
                        miso_oe_q <= 1'b1;
                        sot_q     <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= ACTIVE;
                        // CPHA=1 presents bit 0 on the first leading edge instead.
                        if (CPHA == 0) begin
                            miso_q   <= bus.outgoing_data[TX_IDX0];
                            tx_cnt_q <= TXC_W'(1);
                        end else begin
                            miso_q   <= 1'b0;
                            tx_cnt_q <= '0;
                        end
                    end
                end
                ACTIVE: begin
                    if (ss_rise) begin
                        state_q <= DONE;
                    end else begin
                        if (sample_edge && (rx_cnt_q < RX_FULL)) begin
                            rx_sh_q[rx_idx_d] <= mosi_s;
                            rx_cnt_q          <= rx_cnt_q + 1'b1;
                            if (rx_cnt_q == RX_LAST) begin
                                rx_full_q <= 1'b1;
                            end
                        end
                        if (shift_edge) begin
                            if (tx_cnt_q < TX_FULL) begin
                                miso_q   <= tx_sh_q[tx_idx_d];
                                tx_cnt_q <= tx_cnt_q + 1'b1;
                            end else begin
                                miso_q <= 1'b0;
                            end
                        end
                    end
                end
                DONE: begin
                    eot_q     <= 1'b1;
                    ferr_q    <= (rx_cnt_q != '0) && (rx_cnt_q < RX_FULL);
                    miso_q    <= 1'b0;
                    miso_oe_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.miso                 = miso_q;
    assign bus.miso_oe              = miso_oe_q;
    assign bus.incoming_data        = incoming_data_q;
    assign bus.incoming_valid       = iv_q;
    assign bus.start_of_transaction = sot_q;
    assign bus.end_of_transaction   = eot_q;
    assign bus.frame_error          = ferr_q;
    assign bus.busy                 = busy_q;

endmodule
